sdf_bf_stage: RTL and testbench
===============================

SDF_BF_STAGE -- requirements
Module: sdf_bf_stage

Interface
REQ-001 SHALL have parameter WIDTH, 8, signed two's-complement sample width per real/imag component.
REQ-002 SHALL have parameter DEPTH, 4, feedback delay length in samples; power of two, at least 1.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, input sample accepted ("beat") on any clk edge where it is high.
REQ-006 SHALL have ports in_re / in_im, input, WIDTH signed, input sample.
REQ-007 SHALL have port out_valid, input-to-output registered, 1, output sample valid this cycle.
REQ-008 SHALL have ports out_re / out_im, output, WIDTH signed, registered butterfly output feeding the downstream complex multiplier.
REQ-009 SHALL have port out_idx, output, clog2(2*DEPTH) bits, frame position of the current output, used by downstream twiddle addressing.

Function
REQ-010 SHALL keep a beat counter cnt of clog2(2*DEPTH) bits that increments by 1 per beat and wraps from 2*DEPTH-1 to 0.
REQ-011 SHALL define phase from cnt MSB: FILL (MSB=0) and BFLY (MSB=1).
REQ-012 In FILL, a beat SHALL emit the delay-line head as output and push the input into the delay line.
REQ-013 In BFLY, a beat SHALL emit (head + in) >>> 1 and push (head - in) >>> 1, both computed at WIDTH+1 bits, then arithmetically shifted (floor); no saturation is needed.
REQ-014 The delay line SHALL advance only on beats; with in_valid low, all state, outputs and out_idx SHALL hold, and out_valid SHALL be 0.
REQ-015 Output latency SHALL be exactly one clk after the beat: out_re/out_im/out_idx registered, out_valid high for exactly that cycle.
REQ-016 out_idx SHALL equal (cnt at beat + DEPTH) mod 2*DEPTH, so BFLY sums carry indices 0..DEPTH-1 and FILL differences carry DEPTH..2*DEPTH-1.
REQ-017 A primed flag SHALL set after the first DEPTH beats following reset; until set, out_valid SHALL stay 0, because outputs are delay-line reset contents.
REQ-018 Once primed, every beat SHALL produce out_valid=1; the stage SHALL never self-flush, and the last DEPTH differences SHALL leave only when further beats arrive.
REQ-019 Real and imaginary paths SHALL be processed identically and independently.

Reset
REQ-020 On rst high, asynchronously: cnt=0, primed=0, all delay-line entries 0, out_re=0, out_im=0, out_idx=0, out_valid=0.
REQ-021 Reset asserted mid-frame SHALL discard the partial frame; the first beat after release is treated as frame index 0.

Structure
REQ-022 A shared package fft_pkg SHALL hold the clog2 helper function and the default WIDTH constant shared with the multiplier stage.
REQ-023 The delay line SHALL be a sub-module sdf_delay_line (WIDTH, DEPTH, clk, rst, shift enable, din re/im, head re/im), implemented as a circular buffer with a wrap-around pointer.
REQ-024 The butterfly arithmetic, counter, primed flag and output registers SHALL reside in sdf_bf_stage.

Verification (WIDTH=8, DEPTH=4)
REQ-025 re = 10,20,...,80 then 0,0,0,0 on consecutive beats, im = 0 -> outputs re 30,40,50,60 (idx 0..3), then -20,-20,-20,-20 (idx 4..7); no out_valid during the first 4 beats.
REQ-026 Extremes: pair 127/127 -> sum 127, diff 0; pair -128/-128 -> sum -128, diff 0; pair 127/-128 -> sum -1, diff 127.
REQ-027 Floor rounding: pair 3/0 -> sum 1, diff 1; pair -3/0 -> sum -2, diff -2; identical results on the im path.
REQ-028 Stall: repeat REQ-025 with in_valid low for 3 cycles between every beat -> identical output sequence; outputs hold and out_valid is 0 during gaps.
REQ-029 Assert rst after 6 beats, then replay REQ-025 -> identical results to REQ-025; out_valid stays 0 until the 5th post-reset beat.
REQ-030 Continuous 3-frame random stream checked against a reference model of REQ-013 -> bit-exact match; out_idx wraps 7 -> 0 with no gap.

Source files
------------

// File: rtl/fft_pkg.sv
// ============================================================================
// fft_pkg : constants, types and helpers shared by the FFT pipeline stages
// Rev 1.0
// ============================================================================
`default_nettype none

package fft_pkg;

  localparam int FFT_WIDTH = 8;

  typedef enum logic [0:0] {
    PH_FILL = 1'b0,
    PH_BFLY = 1'b1
  } phase_e;

  // Smallest n such that 2**n >= v; clog2(1) = 0.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sdf_delay_line.sv
// ============================================================================
// sdf_delay_line : DEPTH-entry complex feedback delay as a circular buffer
// Rev 1.0
// ============================================================================
`default_nettype none

module sdf_delay_line
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    shift_en_i,
  input  logic signed [WIDTH-1:0] din_re_i,
  input  logic signed [WIDTH-1:0] din_im_i,
  output logic signed [WIDTH-1:0] head_re_o,
  output logic signed [WIDTH-1:0] head_im_o
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic signed [WIDTH-1:0] mem_re_q [DEPTH];
  logic signed [WIDTH-1:0] mem_im_q [DEPTH];
  logic [PW-1:0]           ptr_q;
  logic [PW-1:0]           ptr_d;

  // The oldest entry sits at the write pointer, so it is read and replaced in one beat.
  assign ptr_d     = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
  assign head_re_o = mem_re_q[ptr_q];
  assign head_im_o = mem_im_q[ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_re_q[i] <= '0;
        mem_im_q[i] <= '0;
      end
    end else if (shift_en_i) begin
      mem_re_q[ptr_q] <= din_re_i;
      mem_im_q[ptr_q] <= din_im_i;
      ptr_q           <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sdf_bf_stage.sv
// ============================================================================
// sdf_bf_stage : radix-2 single-path delay-feedback butterfly stage
// Rev 1.0
// ============================================================================
`default_nettype none

module sdf_bf_stage
  import fft_pkg::*;
#(
  parameter int WIDTH = FFT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic signed [WIDTH-1:0]       in_re,
  input  logic signed [WIDTH-1:0]       in_im,
  output logic                          out_valid,
  output logic signed [WIDTH-1:0]       out_re,
  output logic signed [WIDTH-1:0]       out_im,
  output logic [clog2(2*DEPTH)-1:0]     out_idx
);

  localparam int CW = clog2(2 * DEPTH);

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    primed_q, primed_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH-1:0] out_re_q, out_re_d;
  logic signed [WIDTH-1:0] out_im_q, out_im_d;
  logic [CW-1:0]           out_idx_q, out_idx_d;

  logic signed [WIDTH-1:0] head_re, head_im;
  logic signed [WIDTH-1:0] push_re, push_im;
  logic signed [WIDTH:0]   sum_re, sum_im, dif_re, dif_im;
  phase_e                  phase;

  assign phase = phase_e'(cnt_q[CW-1]);

  // One guard bit keeps the sum/difference exact; dropping the LSB is a floor halving.
  assign sum_re = {head_re[WIDTH-1], head_re} + {in_re[WIDTH-1], in_re};
  assign sum_im = {head_im[WIDTH-1], head_im} + {in_im[WIDTH-1], in_im};
  assign dif_re = {head_re[WIDTH-1], head_re} - {in_re[WIDTH-1], in_re};
  assign dif_im = {head_im[WIDTH-1], head_im} - {in_im[WIDTH-1], in_im};

  sdf_delay_line #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dl (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (in_valid),
    .din_re_i   (push_re),
    .din_im_i   (push_im),
    .head_re_o  (head_re),
    .head_im_o  (head_im)
  );

  always_comb begin
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_idx_d   = out_idx_q;
    push_re     = in_re;
    push_im     = in_im;

    if (phase == PH_BFLY) begin
      push_re = dif_re[WIDTH:1];
      push_im = dif_im[WIDTH:1];
    end

    if (in_valid) begin
      cnt_d       = (cnt_q == CW'(2 * DEPTH - 1)) ? '0 : cnt_q + CW'(1);
      primed_d    = primed_q | (cnt_q == CW'(DEPTH - 1));
      out_valid_d = primed_q;
      // 2*DEPTH is a power of two, so the CW-bit add wraps modulo the frame length.
      out_idx_d   = cnt_q + CW'(DEPTH);
      if (phase == PH_BFLY) begin
        out_re_d = sum_re[WIDTH:1];
        out_im_d = sum_im[WIDTH:1];
      end else begin
        out_re_d = head_re;
        out_im_d = head_im;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      primed_q    <= primed_d;
      out_valid_q <= out_valid_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_idx_q   <= out_idx_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;
  assign out_idx   = out_idx_q;

endmodule

`default_nettype wire

// File: tb/tb_sdf_bf_stage.sv
// ============================================================================
// tb_sdf_bf_stage : scoreboard bench for sdf_bf_stage (WIDTH=8, DEPTH=4)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sdf_bf_stage;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic signed [7:0] in_re = '0;
  logic signed [7:0] in_im = '0;
  logic              out_valid;
  logic signed [7:0] out_re;
  logic signed [7:0] out_im;
  logic [2:0]        out_idx;

  sdf_bf_stage #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [7:0] re;
    logic signed [7:0] im;
    logic [2:0]        idx;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  bit   have_last = 0;
  bit   chk_hold = 0;
  int   total = 0;
  int   bad = 0;

  // reference model state
  int   m_re[$];
  int   m_im[$];
  int   m_cnt;
  bit   m_primed;

  int basic_re[12] = '{10, 20, 30, 40, 50, 60, 70, 80, 0, 0, 0, 0};
  int basic_ex[8]  = '{30, 40, 50, 60, -20, -20, -20, -20};
  int edge_in[20]  = '{127, -128, 127, 3, 127, -128, -128, 0,
                       -3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int edge_ex[16]  = '{127, -128, -1, 1, 0, 0, 127, 1,
                       -2, 0, 0, 0, -2, 0, 0, 0};

  // monitor: sampled 1 time unit after each rising edge
  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      total++;
      if (chk_hold && !in_valid) begin
        bad++;
        $display("FAIL gap_valid: out_valid=1 want 0 with no beat");
      end else if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_out: got re=%0d im=%0d idx=%0d, none expected",
                 out_re, out_im, out_idx);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (out_re !== e.re || out_im !== e.im || out_idx !== e.idx) begin
          bad++;
          $display("FAIL out_sample: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                   out_re, out_im, out_idx, e.re, e.im, e.idx);
        end
        last_exp  = e;
        have_last = 1;
      end
    end else if (chk_hold && !in_valid && have_last) begin
      total++;
      if (out_re !== last_exp.re || out_im !== last_exp.im || out_idx !== last_exp.idx) begin
        bad++;
        $display("FAIL hold: got re=%0d im=%0d idx=%0d want re=%0d im=%0d idx=%0d",
                 out_re, out_im, out_idx, last_exp.re, last_exp.im, last_exp.idx);
      end
    end
  end

  task automatic push_exp(input int re, input int im, input int idx);
    exp_t e;
    e.re  = 8'(re);
    e.im  = 8'(im);
    e.idx = 3'(idx);
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_re.delete();
    m_im.delete();
    for (int i = 0; i < 4; i++) begin
      m_re.push_back(0);
      m_im.push_back(0);
    end
    m_cnt    = 0;
    m_primed = 0;
  endtask

  task automatic model_beat(input int re, input int im);
    int hr, hi, orr, oi;
    hr = m_re.pop_front();
    hi = m_im.pop_front();
    if (m_cnt < 4) begin
      orr = hr;
      oi  = hi;
      m_re.push_back(re);
      m_im.push_back(im);
    end else begin
      orr = (hr + re) >>> 1;
      oi  = (hi + im) >>> 1;
      m_re.push_back((hr - re) >>> 1);
      m_im.push_back((hi - im) >>> 1);
    end
    if (m_primed) push_exp(orr, oi, (m_cnt + 4) % 8);
    if (m_cnt == 3) m_primed = 1;
    m_cnt = (m_cnt + 1) % 8;
  endtask

  // called at a falling edge; the beat lands on the next rising edge
  task automatic beat(input int re, input int im);
    in_valid = 1'b1;
    in_re    = 8'(re);
    in_im    = 8'(im);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_re !== 8'sd0 || out_im !== 8'sd0 || out_idx !== 3'd0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b re=%0d im=%0d idx=%0d want all 0",
               out_valid, out_re, out_im, out_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    have_last = 0;
    chk_hold  = 0;
    model_reset();
  endtask

  task automatic check_drained(input string name);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: %0d outputs still pending, want 0", name, sb.size());
    end
  endtask

  task automatic exp_basic();
    for (int i = 0; i < 8; i++) push_exp(basic_ex[i], 0, i);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    do_reset();

    // basic frame: no output for the first 4 beats
    exp_basic();
    for (int k = 0; k < 12; k++) beat(basic_re[k], 0);
    check_drained("basic");

    // extremes and floor rounding, im path mirrors re
    do_reset();
    for (int i = 0; i < 16; i++) push_exp(edge_ex[i], edge_ex[i], i % 8);
    for (int k = 0; k < 20; k++) beat(edge_in[k], edge_in[k]);
    check_drained("edge");

    // stalls of 3 idle cycles between beats
    do_reset();
    exp_basic();
    for (int k = 0; k < 12; k++) begin
      beat(basic_re[k], 0);
      if (k >= 4) chk_hold = 1;
      idle(3);
    end
    chk_hold = 0;
    check_drained("stall");

    // reset after 6 beats, then full replay
    do_reset();
    push_exp(30, 0, 0);
    push_exp(40, 0, 1);
    for (int k = 0; k < 6; k++) beat(basic_re[k], 0);
    check_drained("partial");
    do_reset();
    exp_basic();
    for (int k = 0; k < 12; k++) begin
      beat(basic_re[k], 0);
      total++;
      if (out_valid !== (k >= 4)) begin
        bad++;
        $display("FAIL replay_valid: beat %0d out_valid=%0b want %0b", k, out_valid, k >= 4);
      end
    end
    check_drained("replay");

    // continuous random stream, 3 frames, against the model
    do_reset();
    for (int k = 0; k < 24; k++) begin
      int r, i;
      r = int'($urandom_range(0, 255)) - 128;
      i = int'($urandom_range(0, 255)) - 128;
      model_beat(r, i);
      beat(r, i);
      total++;
      if (out_valid !== (k >= 4)) begin
        bad++;
        $display("FAIL stream_valid: beat %0d out_valid=%0b want %0b", k, out_valid, k >= 4);
      end
    end
    check_drained("stream");

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
